// File: rtl/hamming_enc_sched.sv
// ----------------------------------------------------------------------------
// hamming_enc_sched
//
// Shares one (11,7) Hamming encoder among NREQ requesters. An arbiter grants
// one requester while idle. The granted requester's 7-bit word is latched, and
// the codeword is computed into a register one cycle later. The result is then
// presented with a valid/ready handshake until the consumer takes it.
//
// Configuration macro:
//   HAMMING_SCHED_RR_EN  defined   -> round-robin arbitration. The search starts
//                                     one above the last grant and starts at 0
//                                     after reset.
//                        undefined -> fixed priority. The lowest index wins and
//                                     there is no pointer state.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   req_valid  in   NREQ     per-requester request strobe
//   req_data   in   7*NREQ   requester i data x[7:1] at [7*i+6:7*i]
//   req_ready  out  NREQ     one-hot grant, asserted only in IDLE
//   out_valid  out  1        codeword available
//   out_code   out  11       codeword z[11:1]
//   out_id     out  IDW      requester that owns out_code
//   out_ready  in   1        consumer accept
// ----------------------------------------------------------------------------
module hamming_enc_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [7*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [10:0]          out_code,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

    state_t            state_reg, state_next;
    logic [6:0]        x_reg;
    logic [IDW-1:0]    id_reg;
    logic [10:0]       code_reg;

    logic [6:0]        data_arr [NREQ];
    logic              any_valid;
    logic [IDW-1:0]    grant_idx;
    logic [NREQ-1:0]   grant_onehot;

    assign any_valid = |req_valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign data_arr[gi]     = req_data[7*gi +: 7];
            assign grant_onehot[gi] = (grant_idx == IDW'(gi));
        end
    endgenerate

    // Check bit h is the XOR of the codeword positions of every set data bit.
    function automatic logic [10:0] encode(input logic [6:0] x);
        logic [3:0] h;
        h = 4'b0000;
        if (x[6]) h = h ^ 4'b1011;
        if (x[5]) h = h ^ 4'b1010;
        if (x[4]) h = h ^ 4'b1001;
        if (x[3]) h = h ^ 4'b0111;
        if (x[2]) h = h ^ 4'b0110;
        if (x[1]) h = h ^ 4'b0101;
        if (x[0]) h = h ^ 4'b0011;
        return {x[6], x[5], x[4], h[3], x[3], x[2], x[1], h[2], x[0], h[1], h[0]};
    endfunction

`ifdef HAMMING_SCHED_RR_EN
    logic [IDW-1:0] ptr_reg;

    // Scan upward from the pointer, wrapping modulo NREQ. The first requesting
    // index wins.
    always_comb begin : rr_search
        int   idx;
        logic found;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (state_reg == IDLE && any_valid) begin
            ptr_reg <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
        end
    end
`else
    // Fixed priority: the descending scan leaves the lowest requesting index.
    always_comb begin
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) grant_idx = IDW'(k);
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    req_ready  = grant_onehot;
                    state_next = ENC;
                end
            end
            ENC: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            id_reg    <= '0;
            code_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && any_valid) begin
                x_reg  <= data_arr[grant_idx];
                id_reg <= grant_idx;
            end
            if (state_reg == ENC) begin
                code_reg <= encode(x_reg);
            end
        end
    end

    assign out_code = code_reg;
    assign out_id   = id_reg;

endmodule
